// File: rtl/ntt_ctrl_if.sv
// ---------------------------------------------------------------------------
// ntt_ctrl_if - control/address bundle between the NTT sequencer and its
// neighbours (input-collection buffer, coefficient buffer, twiddle ROM,
// output serializer).
//
//   start      run request from the input-collection buffer
//   hold       issue stall
//   busy/done  transform in progress / one-cycle completion pulse
//   stage      stage currently issuing (0..6)
//   rd_en, rd_addr_a, rd_addr_b, tw_idx   read pair and twiddle index
//   wr_en, wr_addr_a, wr_addr_b           write-back pair
//
// Modports: master drives start/hold and observes the rest (environment),
// slave is the sequencer itself.
// ---------------------------------------------------------------------------
interface ntt_ctrl_if;
   logic       start;
   logic       hold;
   logic       busy;
   logic       done;
   logic [2:0] stage;
   logic       rd_en;
   logic [6:0] rd_addr_a;
   logic [6:0] rd_addr_b;
   logic [6:0] tw_idx;
   logic       wr_en;
   logic [6:0] wr_addr_a;
   logic [6:0] wr_addr_b;

   modport master (
      output start, hold,
      input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx,
             wr_en, wr_addr_a, wr_addr_b
   );

   modport slave (
      input  start, hold,
      output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_idx,
             wr_en, wr_addr_a, wr_addr_b
   );
endinterface

// File: rtl/ntt_ctrl.sv
// ---------------------------------------------------------------------------
// ntt_ctrl - sequencer for the 128-point in-place Cooley-Tukey NTT core.
//
// Walks 7 stages of 64 butterflies. For each butterfly it issues the operand
// pair (rd_addr_a, rd_addr_b) and the bit-reversed-order twiddle index, then
// replays the same pair as the write-back exactly RD_LAT+BF_LAT cycles later.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   ntt_ctrl_if.slave (start/hold in; status, read and write out)
//
// All outputs are registered. Inputs act like start does: the value sampled
// at a clock edge decides what the outputs show in the following cycle, so a
// hold sampled at the edge entering cycle t suppresses the read of cycle t.
// ---------------------------------------------------------------------------
module ntt_ctrl #(
   parameter int N      = 128,
   parameter int RD_LAT = 1,
   parameter int BF_LAT = 4
) (
   input  logic       clk,
   input  logic       rst,
   ntt_ctrl_if.slave  bus
);

   localparam int AW         = $clog2(N);       // address width (7)
   localparam int CW         = AW - 1;          // butterfly index width (6)
   localparam int LAST_STAGE = AW - 1;          // stages 0..6
   localparam int DLY        = RD_LAT + BF_LAT; // read-to-write distance
   localparam int DW         = $clog2(DLY);

   typedef logic [AW-1:0] addr_t;
   typedef logic [CW:0]   cnt_t;   // one extra bit: counts 0..64
   typedef logic [2:0]    stg_t;
   typedef logic [DW-1:0] dcnt_t;

   localparam cnt_t  CNT_END  = cnt_t'(N / 2);
   localparam dcnt_t DCNT_END = dcnt_t'(DLY - 1);
   localparam stg_t  STG_END  = stg_t'(LAST_STAGE);
   localparam stg_t  STG_AW   = stg_t'(AW);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   typedef struct packed {
      logic  en;
      addr_t a;
      addr_t b;
   } wb_t;

   state_t        state, state_n;
   stg_t          s, s_n;
   cnt_t          cnt, cnt_n;       // butterflies already issued this stage
   dcnt_t         dcnt, dcnt_n;     // drain cycle index
   logic          issue;            // a read is issued in the next cycle
   logic [CW-1:0] c;                // index of the butterfly being issued
   addr_t         len, g, j, addr_a, addr_b, tw;
   wb_t           pipe [DLY-1];     // last slot is the wr_* register itself

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned; otherwise synthesis infers a latch.
      state_n = state;
      s_n     = s;
      cnt_n   = cnt;
      dcnt_n  = dcnt;
      issue   = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_n = ISSUE;
               s_n     = '0;
               cnt_n   = '0;
               issue   = !bus.hold;
            end
         end
         ISSUE: begin
            // cnt reaching 64 means the last read is on the outputs now.
            if (cnt == CNT_END) begin
               state_n = DRAIN;
               dcnt_n  = '0;
            end else begin
               issue = !bus.hold;
            end
         end
         DRAIN: begin
            if (dcnt == DCNT_END) begin
               if (s == STG_END) begin
                  state_n = DONE;
               end else begin
                  // Next stage's first read lands one cycle after this
                  // stage's last write.
                  state_n = ISSUE;
                  s_n     = s + 1'b1;
                  cnt_n   = '0;
                  issue   = !bus.hold;
               end
            end else begin
               dcnt_n = dcnt + 1'b1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      c = cnt_n[CW-1:0];
      if (issue) cnt_n = cnt_n + 1'b1;
   end

   // -------------------------------------------------------------------------
   // Address generation for stage s_n, butterfly c:
   //   len = 64>>s, g = c>>(6-s), j = c & (len-1)
   //   a = (g<<(7-s)) | j, b = a + len, tw = (1<<s) + g
   // -------------------------------------------------------------------------
   always_comb begin
      len    = addr_t'(N / 2) >> s_n;
      g      = addr_t'(c) >> (STG_END - s_n);
      j      = addr_t'(c) & (len - 1'b1);
      addr_a = (g << (STG_AW - s_n)) | j;
      addr_b = addr_a + len;
      tw     = (addr_t'(1) << s_n) + g;
   end

   // -------------------------------------------------------------------------
   // FSM and counter state
   // -------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         s     <= '0;
         cnt   <= '0;
         dcnt  <= '0;
      end else begin
         state <= state_n;
         s     <= s_n;
         cnt   <= cnt_n;
         dcnt  <= dcnt_n;
      end
   end

   assign bus.stage = s;

   // -------------------------------------------------------------------------
   // Registered outputs and write-back delay line
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.rd_en     <= 1'b0;
         bus.rd_addr_a <= '0;
         bus.rd_addr_b <= '0;
         bus.tw_idx    <= '0;
         bus.wr_en     <= 1'b0;
         bus.wr_addr_a <= '0;
         bus.wr_addr_b <= '0;
         // NOTE: the delay line is reset along with everything else because
         // a write still in flight must not reach the buffer after reset.
         for (int i = 0; i < DLY - 1; i++) pipe[i] <= '0;
      end else begin
         bus.busy  <= (state_n != IDLE);
         bus.done  <= (state_n == DONE);
         bus.rd_en <= issue;
         // Idle cycles keep the last addresses; consumers ignore them.
         if (issue) begin
            bus.rd_addr_a <= addr_a;
            bus.rd_addr_b <= addr_b;
            bus.tw_idx    <= tw;
         end

         pipe[0] <= {bus.rd_en, bus.rd_addr_a, bus.rd_addr_b};
         for (int i = 1; i < DLY - 1; i++) pipe[i] <= pipe[i-1];
         {bus.wr_en, bus.wr_addr_a, bus.wr_addr_b} <= pipe[DLY-2];
      end
   end

endmodule

// File: tb/tb_ntt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ntt_ctrl - scoreboard bench for ntt_ctrl.
//
// Each run pushes its expected reads, writes and done cycle into queues from
// a textbook triple-loop butterfly walk; an independent monitor pops and
// compares whenever the DUT shows rd_en, wr_en or done. Cycle numbers are
// relative to the cycle in which start is sampled (cycle 0). Hold is driven
// one cycle ahead of the issue slot it suppresses (sampled on the edge that
// enters that slot), so holding slots 150..159 means hold=1 in cycles 149..158.
// ---------------------------------------------------------------------------
module tb_ntt_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;

   ntt_ctrl_if bus ();

   ntt_ctrl #(.N(128), .RD_LAT(1), .BF_LAT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      int         s;
      logic [6:0] a;
      logic [6:0] b;
      logic [6:0] tw;
   } exp_t;

   exp_t rd_q[$];
   exp_t wr_q[$];
   int   done_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int gc    = 0;
   int t0    = 0;
   bit mon_en = 1'b0;

   // per-run observations
   int           rd_cnt, wr_cnt, wr_idx, done_rel, busy_first, busy_last, hold_rd;
   logic [20:0]  rd_log [0:599];
   int           hit    [0:127];
   logic [127:0] mask   [0:6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({bus.busy, bus.done, bus.stage, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b,
                  bus.tw_idx, bus.wr_en, bus.wr_addr_a, bus.wr_addr_b});
   endfunction

   // Expected schedule: butterflies in (block k, offset j) order, one issue
   // slot per cycle skipping held slots, 5 drain cycles after each stage.
   task automatic push_expect(input int lo, input int hi);
      int   t;
      exp_t e;
      t = 1;
      for (int s = 0; s < 7; s++) begin
         int len;
         len = 64 >> s;
         for (int k = 0; k < 128; k += 2 * len) begin
            for (int j = 0; j < len; j++) begin
               while (t >= lo && t <= hi) t++;
               e.cyc = t;
               e.s   = s;
               e.a   = 7'(k + j);
               e.b   = 7'(k + j + len);
               e.tw  = 7'((1 << s) + k / (2 * len));
               rd_q.push_back(e);
               e.cyc = t + 5;
               wr_q.push_back(e);
               t++;
            end
         end
         t += 5;
      end
      done_q.push_back(t);
   endtask

   task automatic clear_stats();
      rd_cnt = 0; wr_cnt = 0; wr_idx = 0; hold_rd = 0;
      done_rel = -1; busy_first = -1; busy_last = -1;
      for (int i = 0; i < 600; i++) rd_log[i] = '1;
      for (int i = 0; i < 128; i++) hit[i] = 0;
      for (int i = 0; i < 7; i++) mask[i] = '0;
   endtask

   // Starts a transform in the current cycle (caller is just after an edge)
   // and drives until relative cycle end_rel.
   task automatic run(input int lo, input int hi, input bit pulses, input int end_rel);
      int rel;
      clear_stats();
      push_expect(lo, hi);
      t0 = gc;
      bus.start = 1'b1;
      bus.hold  = 1'b0;
      while (gc - t0 < end_rel) begin
         @(posedge clk); #1;
         rel = gc - t0;
         bus.start = pulses && (rel == 10 || rel == 300 || rel == 484);
         bus.hold  = (rel >= lo - 1 && rel <= hi - 1);
      end
      bus.start = 1'b0;
      bus.hold  = 1'b0;
   endtask

   task automatic check_run(input string tag, input int exp_done);
      int bad;
      check({tag, " rd count"}, 64'(rd_cnt), 64'd448);
      check({tag, " wr count"}, 64'(wr_cnt), 64'd448);
      check({tag, " done cycle"}, 64'(done_rel), 64'(exp_done));
      check({tag, " busy first"}, 64'(busy_first), 64'd1);
      check({tag, " busy last"}, 64'(busy_last), 64'(exp_done));
      check({tag, " queues empty"}, 64'(rd_q.size() + wr_q.size() + done_q.size()), 64'd0);
      bad = 0;
      for (int i = 0; i < 128; i++) if (hit[i] != 7) bad++;
      check({tag, " addr written 7x"}, 64'(bad), 64'd0);
      for (int st = 0; st < 7; st++)
         check($sformatf("%s stage %0d coverage", tag, st), 64'($countones(mask[st])), 64'd128);
      check({tag, " cycle 1 read"}, 64'(rd_log[1]), 64'({7'd0, 7'd64, 7'd1}));
   endtask

   // cycle counter
   initial forever begin
      @(posedge clk);
      gc = gc + 1;
   end

   // monitor / scoreboard
   int   rel_m;
   int   st_m;
   exp_t e_m;
   int   d_m;
   initial forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
         rel_m = gc - t0;
         if (bus.busy) begin
            if (busy_first < 0) busy_first = rel_m;
            busy_last = rel_m;
         end
         if (bus.rd_en) begin
            rd_cnt++;
            if (rel_m >= 0 && rel_m < 600) rd_log[rel_m] = {bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx};
            if (rel_m >= 150 && rel_m <= 159) hold_rd++;
            if (rd_q.size() == 0) begin
               check("rd unexpected", 64'(rel_m), 64'(-1));
            end else begin
               e_m = rd_q.pop_front();
               check("rd cycle", 64'(rel_m), 64'(e_m.cyc));
               check("rd a/b/tw", 64'({bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx}),
                     64'({e_m.a, e_m.b, e_m.tw}));
               check("rd stage", 64'(bus.stage), 64'(e_m.s));
            end
         end
         if (bus.wr_en) begin
            wr_cnt++;
            hit[bus.wr_addr_a]++;
            hit[bus.wr_addr_b]++;
            st_m = wr_idx / 64;
            if (st_m < 7) begin
               mask[st_m][bus.wr_addr_a] = 1'b1;
               mask[st_m][bus.wr_addr_b] = 1'b1;
            end
            wr_idx++;
            if (wr_q.size() == 0) begin
               check("wr unexpected", 64'(rel_m), 64'(-1));
            end else begin
               e_m = wr_q.pop_front();
               check("wr cycle", 64'(rel_m), 64'(e_m.cyc));
               check("wr a/b", 64'({bus.wr_addr_a, bus.wr_addr_b}), 64'({e_m.a, e_m.b}));
            end
         end
         if (bus.done) begin
            done_rel = rel_m;
            if (done_q.size() == 0) begin
               check("done unexpected", 64'(rel_m), 64'(-1));
            end else begin
               d_m = done_q.pop_front();
               check("done from schedule", 64'(rel_m), 64'(d_m));
            end
         end
      end
   end

   initial begin
      bus.start = 1'b0;
      bus.hold  = 1'b0;

      // reset state
      #2 rst = 1'b1;
      #1 check("reset outputs", all_outs(), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("post-reset outputs", all_outs(), 64'd0);
      mon_en = 1'b1;

      // Run A: no holds, stray starts at 10, 300, 484 must be ignored.
      @(posedge clk); #1;
      run(-1, -1, 1'b1, 486);
      check_run("A", 484);
      check("A s1 c32 read", 64'(rd_log[102]), 64'({7'd64, 7'd96, 7'd3}));
      check("A s6 c63 read", 64'(rd_log[478]), 64'({7'd126, 7'd127, 7'd127}));

      // Run B: started at A's cycle 486; issue slots 150..159 held.
      run(150, 159, 1'b0, 500);
      check_run("B", 494);
      check("B reads in held slots", 64'(hold_rd), 64'd0);

      // Run C: asynchronous reset in the middle of cycle 200.
      @(posedge clk); #1;
      run(-1, -1, 1'b0, 200);
      #2 rst = 1'b1;
      #1 check("mid-run async reset outputs", all_outs(), 64'd0);
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      rd_cnt = 0;
      wr_cnt = 0;
      repeat (20) @(posedge clk);
      #1;
      check("wr after reset", 64'(wr_cnt), 64'd0);
      check("rd after reset", 64'(rd_cnt), 64'd0);
      check("idle outputs after reset", 64'(bus.busy), 64'd0);

      // Run D: full transform after reset.
      run(-1, -1, 1'b0, 490);
      check_run("D", 484);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencer for the 128-point in-place NTT compute core. It walks the 7 Cooley-Tukey stages of 64 butterflies each. For every butterfly it issues coefficient-buffer read addresses and a bit-reversed-order twiddle index. It replays the same addresses as the write-back after the fixed read-plus-butterfly pipeline delay. It sits between the input-collection buffer, which pulses `start`, and the output serializer, which consumes `done`.

## Interface
Parameters:
- `N`, 128: transform length; the block is defined for `N`=128 only.
- `RD_LAT`, 1: coefficient-buffer read latency in cycles.
- `BF_LAT`, 4: butterfly pipeline latency in cycles.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to run a full transform; honoured only in IDLE.
- `hold`  in  1  issue stall; freezes butterfly issue, does not stall write-back.
- `busy`  out  1  high from first issue cycle through the `done` cycle.
- `done`  out  1  one-cycle pulse after the final write-back.
- `stage`  out  3  current issuing stage, 0..6.
- `rd_en`  out  1  read strobe for pair (`rd_addr_a`, `rd_addr_b`).
- `rd_addr_a`  out  7  top butterfly operand address.
- `rd_addr_b`  out  7  bottom butterfly operand address.
- `tw_idx`  out  7  twiddle ROM index, valid with `rd_en`.
- `wr_en`  out  1  write-back strobe.
- `wr_addr_a`  out  7  write address for butterfly output a.
- `wr_addr_b`  out  7  write address for butterfly output b.

## Operation
- FSM states are IDLE, ISSUE, DRAIN, DONE.
- IDLE -> ISSUE when `start`=1. Stage and butterfly counter `c` are cleared.
- ISSUE behaviour for stage s:
  - If `hold`=0: `rd_en`=1, then `c` increments.
  - If `hold`=1: `rd_en`=0 and `c` holds.
  - After the issue with `c`=63, go to DRAIN.
- DRAIN lasts exactly `RD_LAT`+`BF_LAT` (5) cycles, with `rd_en`=0. `hold` is ignored.
  - If s<6: s increments, `c` clears, go to ISSUE.
  - If s=6: go to DONE.
- DONE lasts 1 cycle with `done`=1, then goes to IDLE.
- Address generation for stage s, counter `c` (6 bits):
  - len = 64>>s
  - g = c>>(6-s)
  - j = c & (len-1)
  - `rd_addr_a` = (g<<(7-s)) | j
  - `rd_addr_b` = `rd_addr_a` + len (no carry out; fits in 7 bits)
  - `tw_idx` = (1<<s) + g, range 1..127
- Write-back uses a (`RD_LAT`+`BF_LAT`)-deep shift register of {`rd_en`, `rd_addr_a`, `rd_addr_b`}.
  - `wr_en`/`wr_addr_*` equal the values issued exactly 5 cycles earlier.
  - This holds regardless of `hold` or FSM state.
- `start` in ISSUE, DRAIN or DONE is ignored, not queued.
- `rst` clears the FSM to IDLE, zeroes every counter, and flushes the shift register. No pending write survives reset.

## Timing
- Reset values: every output is 0, including `wr_en` and all addresses.
- All outputs are registered.
- Cycle 0 is the cycle in which `start`=1 is sampled in IDLE.
- With no holds:
  - Stage s reads occupy cycles 1+69s .. 64+69s.
  - DRAIN for stage s occupies cycles 65+69s .. 69+69s.
  - The last read is at cycle 478; the last write is at cycle 483.
  - `done`=1 at cycle 484; IDLE at cycle 485.
  - `busy`=1 for cycles 1..484.
- Read-to-write distance is fixed at 5 cycles.
- Stage s+1's first read occurs 1 cycle after stage s's last write, so the buffer must return post-write data on the following cycle.
- Each ISSUE cycle with `hold`=1 delays `done` by exactly 1 cycle.
- `start` in cycle 485 (IDLE) is accepted.
- When `rd_en`/`wr_en`=0, address outputs keep their last value; downstream logic ignores them.

## Test plan
- Single run, `hold`=0:
  - 448 `rd_en` cycles and 448 `wr_en` cycles.
  - Cycle 1 reads a=0, b=64, tw=1.
  - Stage 1, c=32 reads a=64, b=96, tw=3.
  - Stage 6, c=63 (cycle 478) reads a=126, b=127, tw=127.
  - `done` at cycle 484.
- Write-back pairing: for every `wr_en` cycle t, (`wr_addr_a`, `wr_addr_b`) equals the read pair at t-5. Each address 0..127 is written exactly twice per stage-pair sum, and once as a or b per stage.
- `hold`=1 for cycles 150..159 (stage 2 issue):
  - No `rd_en` in those cycles.
  - Writes continue until drained.
  - `done` at cycle 494; addresses unchanged.
- `start` re-pulsed at cycles 10, 300 and 484: all ignored. The second `start` at cycle 486 is accepted, and its first read is at cycle 487 with a=0, b=64.
- `rst` asserted mid-transform at cycle 200:
  - All outputs are 0 immediately (asynchronous).
  - No `wr_en` afterwards.
  - `start` after release runs a full 484-cycle transform.
